beta_sequencer: RTL and testbench
=================================

# beta_sequencer

Multi-cycle instruction sequencer for the Beta-style CPU. It owns the single shared memory port, alternating instruction fetch and LD/ST data access through a request/ready handshake. It gates the per-phase enables (IR load, PC update, register-file write) around the combinational opcode decoder, and injects ILLOP, IRQ and bus-timeout traps by overriding PCSEL and the write address.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles mem_req may wait for mem_ready before a timeout trap; legal 1..65535.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- op_code  in  6  opcode field of the instruction register (IR[31:26]).
- pc_sup  in  1  PC[31], the supervisor bit; IRQ is masked while 1.
- IRQ  in  1  level interrupt request.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  write request; valid only with mem_req.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_en  out  1  load IR from memory read data.
- pc_en  out  1  load PC from PCSEL mux.
- rf_we  out  1  register-file write enable (replaces decoder WERF).
- trap  out  1  force PCSEL := trap_pcsel and WASEL := 1 (XP), WDSEL := 0 (PC+4).
- trap_pcsel  out  3  3 = ILLOP vector, 4 = XAdr (IRQ) vector.
- trap_cause  out  2  cause of the last trap: 0 none, 1 ILLOP, 2 IRQ, 3 timeout.

## Operation
- States: S_FETCH, S_EXEC, S_MEM, S_TRAP. Moore state register; the mem_ready-qualified strobes are combinational from state and mem_ready.
- RESET → S_FETCH, timeout counter = 0, trap_cause = 0.
- Opcode classes:
  - ALU: 0x20, 0x21, 0x24–0x26, 0x28–0x2E, plus the same set +0x10 (constant forms).
  - Control: JMP 0x1B, BEQ 0x1C, BNE 0x1D.
  - Memory: LD 0x18, ST 0x19, LDR 0x1F.
  - Every other opcode is illegal, including 0x22 and 0x23.
- S_FETCH:
  - Outputs: mem_req=1, addr_sel=0, mem_we=0.
  - If mem_ready: ir_en=1 and go to S_EXEC.
  - IRQ check: on entry to S_FETCH, if IRQ && !pc_sup (macro permitting), go to S_TRAP with cause IRQ instead. No request is issued that cycle.
- S_EXEC:
  - ALU: rf_we=1, pc_en=1, go to S_FETCH.
  - Control: pc_en=1, rf_we=1 (link write), go to S_FETCH.
  - Memory: go to S_MEM.
  - Illegal: go to S_TRAP with cause ILLOP.
- S_MEM:
  - Outputs: mem_req=1, addr_sel=1. mem_we=1 for ST only; LDR uses addr_sel=1 (the decoder selects the PC-relative ALU operand).
  - On mem_ready: pc_en=1, rf_we=1 unless ST, go to S_FETCH.
- S_TRAP (one cycle):
  - Outputs: trap=1, pc_en=1, rf_we=1; trap_pcsel = 4 for IRQ, else 3.
  - trap_cause is updated at entry and held until the next trap.
  - Go to S_FETCH.
  - The IRQ check is suppressed on this return because the vector sets pc_sup.
- Timeout:
  - The counter increments each cycle with mem_req && !mem_ready, and clears on mem_ready or on leaving S_FETCH/S_MEM.
  - When the count reaches TIMEOUT_CYCLES with no ready: mem_req drops, go to S_TRAP with cause 3 and trap_pcsel 3. No ir_en, no data rf_we.
  - mem_ready arriving in the same cycle the counter hits the limit wins: normal completion.
- Outputs not listed for a state are 0.

## Timing
- Reset values of all outputs: 0 except mem_req=1, since the S_FETCH request is issued the cycle after RESET deasserts. While RESET is high, all outputs are forced to 0.
- Latency with zero-wait memory:
  - ALU and control instructions: 2 cycles.
  - LD, ST, LDR: 3 cycles.
  - Traps: +1 cycle.
- Each wait cycle on mem_ready adds 1 cycle.
- mem_req stays asserted, with stable mem_we and addr_sel, until mem_ready or timeout. It is never withdrawn early except on timeout or RESET.
- RESET mid-request drops mem_req in the next cycle. No pc_en, ir_en or rf_we fires in a cycle where RESET is high.
- IRQ is sampled only on the S_FETCH entry cycle. An IRQ pulse shorter than one instruction may be missed; this is by design.

## Configuration
- BETA_SEQ_IRQ_EN defined: IRQ is honoured as described above.
- BETA_SEQ_IRQ_EN undefined: the IRQ input is ignored, trap_pcsel is never 4, and trap_cause never reports 2. ILLOP and timeout traps are unchanged.

## Test plan
- ADDC (0x30) with mem_ready tied 1 → ir_en in cycle 1; pc_en and rf_we in cycle 2; mem_req reasserted in cycle 3.
- LD (0x18) with mem_ready delayed 3 cycles in S_MEM → mem_req=1, addr_sel=1, mem_we=0 held for 4 cycles, then pc_en=1 and rf_we=1 together.
- ST (0x19) → mem_we=1 in S_MEM, rf_we stays 0 throughout.
- Opcode 0x22 → S_TRAP for 1 cycle with trap=1, trap_pcsel=3, rf_we=1, trap_cause=1.
- IRQ=1, pc_sup=0 at end of an instruction → trap_pcsel=4, trap_cause=2. Repeat with pc_sup=1 → no trap.
- TIMEOUT_CYCLES=4 with mem_ready held 0 → mem_req high for exactly 4 cycles, then trap=1, trap_cause=3. RESET asserted mid-wait → all outputs 0 in the next cycle.

Source files
------------

// File: rtl/beta_sequencer_if.sv
// Sequencer <-> datapath/memory bundle for the Beta CPU sequencer.
// master = sequencer side, slave = datapath + memory side.
interface beta_sequencer_if;
    logic [5:0] op_code;
    logic       pc_sup;
    logic       IRQ;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_en;
    logic       pc_en;
    logic       rf_we;
    logic       trap;
    logic [2:0] trap_pcsel;
    logic [1:0] trap_cause;

    modport master (
        input  op_code, pc_sup, IRQ, mem_ready,
        output mem_req, mem_we, addr_sel, ir_en, pc_en, rf_we,
               trap, trap_pcsel, trap_cause
    );

    modport slave (
        output op_code, pc_sup, IRQ, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_en, pc_en, rf_we,
               trap, trap_pcsel, trap_cause
    );
endinterface

// File: rtl/beta_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer with ILLOP, IRQ and bus-timeout traps.
// Build option: define BETA_SEQ_IRQ_EN to honour the IRQ input (ignored otherwise).
module beta_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             RESET,
    beta_sequencer_if.master sif
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [1:0]  CAUSE_ILLOP   = 2'd1;
    localparam logic [1:0]  CAUSE_IRQ     = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'd3;
    localparam logic [15:0] WAIT_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]  cause_reg, cause_next;
    logic        irq_chk_reg, irq_chk_next;

    // Opcode class tables, one bit per opcode, resolved at elaboration.
    logic [63:0] alu_map;
    logic [63:0] ctl_map;
    logic [63:0] mem_map;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_dec
            localparam logic [5:0] OP = 6'(gi);
            assign alu_map[gi] = OP[5] && !(OP[3:0] inside {4'h2, 4'h3, 4'h7, 4'hF});
            assign ctl_map[gi] = (OP inside {6'h1B, 6'h1C, 6'h1D});
            assign mem_map[gi] = (OP inside {6'h18, 6'h19, 6'h1F});
        end
    endgenerate

    logic op_alu, op_ctl, op_mem, op_st;
    assign op_alu = alu_map[sif.op_code];
    assign op_ctl = ctl_map[sif.op_code];
    assign op_mem = mem_map[sif.op_code];
    assign op_st  = (sif.op_code == 6'h19);

    logic irq_take;
`ifdef BETA_SEQ_IRQ_EN
    // Only the first S_FETCH cycle after a completed instruction may divert to IRQ.
    assign irq_take = irq_chk_reg & sif.IRQ & ~sif.pc_sup;
`else
    logic unused_irq;
    assign unused_irq = irq_chk_reg ^ sif.IRQ ^ sif.pc_sup;
    assign irq_take   = 1'b0;
`endif

    logic wait_expired;
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    logic       req_int, we_int, asel_int, ir_en_int, pc_en_int, rf_we_int, trap_int;
    logic [2:0] pcsel_int;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        cause_next    = cause_reg;
        irq_chk_next  = 1'b0;
        req_int       = 1'b0;
        we_int        = 1'b0;
        asel_int      = 1'b0;
        ir_en_int     = 1'b0;
        pc_en_int     = 1'b0;
        rf_we_int     = 1'b0;
        trap_int      = 1'b0;
        pcsel_int     = 3'd0;

        case (state_reg)
            S_FETCH: begin
                if (irq_take) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_IRQ;
                end else begin
                    req_int = 1'b1;
                    if (sif.mem_ready) begin
                        ir_en_int  = 1'b1;
                        state_next = S_EXEC;
                    end else if (wait_expired) begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 16'd1;
                    end
                end
            end

            S_EXEC: begin
                if (op_alu || op_ctl) begin
                    rf_we_int    = 1'b1;
                    pc_en_int    = 1'b1;
                    state_next   = S_FETCH;
                    irq_chk_next = 1'b1;
                end else if (op_mem) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLOP;
                end
            end

            S_MEM: begin
                req_int  = 1'b1;
                asel_int = 1'b1;
                we_int   = op_st;
                if (sif.mem_ready) begin
                    pc_en_int    = 1'b1;
                    rf_we_int    = ~op_st;
                    state_next   = S_FETCH;
                    irq_chk_next = 1'b1;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end

            S_TRAP: begin
                // The trap vector sets pc_sup, so the return fetch skips the IRQ check.
                trap_int   = 1'b1;
                pc_en_int  = 1'b1;
                rf_we_int  = 1'b1;
                pcsel_int  = (cause_reg == CAUSE_IRQ) ? 3'd4 : 3'd3;
                state_next = S_FETCH;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            cause_reg    <= '0;
            irq_chk_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            cause_reg    <= cause_next;
            irq_chk_reg  <= irq_chk_next;
        end
    end

    // Every strobe is held low while RESET is high.
    assign sif.mem_req    = req_int   & ~RESET;
    assign sif.mem_we     = we_int    & ~RESET;
    assign sif.addr_sel   = asel_int  & ~RESET;
    assign sif.ir_en      = ir_en_int & ~RESET;
    assign sif.pc_en      = pc_en_int & ~RESET;
    assign sif.rf_we      = rf_we_int & ~RESET;
    assign sif.trap       = trap_int  & ~RESET;
    assign sif.trap_pcsel = RESET ? 3'd0 : pcsel_int;
    assign sif.trap_cause = RESET ? 2'd0 : cause_reg;
endmodule

// File: tb/tb_beta_sequencer.sv
// Self-checking bench for beta_sequencer: per-cycle expected outputs are queued
// with the stimulus that produces them and compared as each cycle is simulated.
module tb_beta_sequencer;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    always #5 clk = ~clk;

    beta_sequencer_if sif();

    beta_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .RESET (RESET),
        .sif   (sif)
    );

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        irq;
        logic        psup;
        logic [5:0]  op;
        logic [11:0] exp;
    } step_t;

    step_t      sq[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] cause  = 2'd0;

    logic [5:0] alu_ops [9] = '{6'h30, 6'h20, 6'h21, 6'h2E, 6'h3E, 6'h34, 6'h1B, 6'h1C, 6'h1D};
    logic [5:0] ill_ops [8] = '{6'h22, 6'h23, 6'h27, 6'h2F, 6'h00, 6'h3F, 6'h1A, 6'h1E};

    // Packed order: req, we, addr_sel, ir_en, pc_en, rf_we, trap, pcsel[2:0], cause[1:0]
    function automatic logic [11:0] v(input logic req, we, as, ir, pc, rf, tr,
                                      input logic [2:0] sel, input logic [1:0] c);
        return {req, we, as, ir, pc, rf, tr, sel, c};
    endfunction

    function automatic logic [11:0] obs();
        return {sif.mem_req, sif.mem_we, sif.addr_sel, sif.ir_en, sif.pc_en, sif.rf_we,
                sif.trap, sif.trap_pcsel, sif.trap_cause};
    endfunction

    task automatic push(input logic rst, rdy, irq, psup, input logic [5:0] op, input logic [11:0] e);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.irq = irq; s.psup = psup; s.op = op; s.exp = e;
        sq.push_back(s);
    endtask

    task automatic p_fetch(input logic [5:0] op, input logic irq, input logic psup);
        push(1'b0, 1'b1, irq, psup, op, v(1, 0, 0, 1, 0, 0, 0, 3'd0, cause));
    endtask

    task automatic p_exec(input logic [5:0] op);
        push(1'b0, 1'b0, 1'b0, 1'b1, op, v(0, 0, 0, 0, 1, 1, 0, 3'd0, cause));
    endtask

    task automatic p_idle(input logic [5:0] op);
        push(1'b0, 1'b0, 1'b0, 1'b1, op, v(0, 0, 0, 0, 0, 0, 0, 3'd0, cause));
    endtask

    task automatic p_trap(input logic [2:0] sel, input logic [1:0] c);
        cause = c;
        push(1'b0, 1'b0, 1'b0, 1'b1, 6'h20, v(0, 0, 0, 0, 1, 1, 1, sel, cause));
    endtask

    task automatic test_reset();
        step_t s; logic [11:0] got; int n = 0;
        cause = 2'd0;
        push(1'b1, 1'b0, 1'b0, 1'b1, 6'h20, 12'h000);
        push(1'b1, 1'b1, 1'b0, 1'b1, 6'h20, 12'h000);
        push(1'b0, 1'b0, 1'b0, 1'b1, 6'h20, v(1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0));
        p_fetch(6'h20, 1'b0, 1'b1);
        p_exec(6'h20);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL reset step %0d got=%h exp=%h", n, got, s.exp); end
            else $display("reset step %0d out=%h", n, got);
            n++;
        end
    endtask

    task automatic test_alu();
        step_t s; logic [11:0] got; int n = 0;
        foreach (alu_ops[i]) begin
            p_fetch(alu_ops[i], 1'b0, 1'b1);
            p_exec(alu_ops[i]);
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL alu step %0d op=%h got=%h exp=%h", n, s.op, got, s.exp); end
            else $display("alu step %0d op=%h out=%h", n, s.op, got);
            n++;
        end
    endtask

    task automatic test_ld();
        step_t s; logic [11:0] got; int n = 0;
        p_fetch(6'h18, 1'b0, 1'b1);
        p_idle(6'h18);
        // Three wait states; ready arrives on the cycle the counter would expire.
        for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, 1'b1, 6'h18, v(1, 0, 1, 0, 0, 0, 0, 3'd0, cause));
        push(1'b0, 1'b1, 1'b0, 1'b1, 6'h18, v(1, 0, 1, 0, 1, 1, 0, 3'd0, cause));
        p_fetch(6'h1F, 1'b0, 1'b1);
        p_idle(6'h1F);
        push(1'b0, 1'b1, 1'b0, 1'b1, 6'h1F, v(1, 0, 1, 0, 1, 1, 0, 3'd0, cause));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL ld step %0d got=%h exp=%h", n, got, s.exp); end
            else $display("ld step %0d out=%h", n, got);
            n++;
        end
    endtask

    task automatic test_st();
        step_t s; logic [11:0] got; int n = 0;
        p_fetch(6'h19, 1'b0, 1'b1);
        p_idle(6'h19);
        push(1'b0, 1'b0, 1'b0, 1'b1, 6'h19, v(1, 1, 1, 0, 0, 0, 0, 3'd0, cause));
        push(1'b0, 1'b1, 1'b0, 1'b1, 6'h19, v(1, 1, 1, 0, 1, 0, 0, 3'd0, cause));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL st step %0d got=%h exp=%h", n, got, s.exp); end
            else $display("st step %0d out=%h", n, got);
            n++;
        end
    endtask

    task automatic test_illop();
        step_t s; logic [11:0] got; int n = 0;
        foreach (ill_ops[i]) begin
            p_fetch(ill_ops[i], 1'b0, 1'b1);
            p_idle(ill_ops[i]);
            p_trap(3'd3, 2'd1);
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL illop step %0d op=%h got=%h exp=%h", n, s.op, got, s.exp); end
            else $display("illop step %0d op=%h out=%h", n, s.op, got);
            n++;
        end
    endtask

    task automatic test_irq();
        step_t s; logic [11:0] got; int n = 0;
        // Fetch right after a trap: IRQ check is suppressed.
        p_fetch(6'h20, 1'b1, 1'b0);
        p_exec(6'h20);
`ifdef BETA_SEQ_IRQ_EN
        push(1'b0, 1'b1, 1'b1, 1'b0, 6'h20, v(0, 0, 0, 0, 0, 0, 0, 3'd0, cause));
        p_trap(3'd4, 2'd2);
        p_fetch(6'h20, 1'b1, 1'b0);
        p_exec(6'h20);
`else
        p_fetch(6'h20, 1'b1, 1'b0);
        p_exec(6'h20);
`endif
        // Supervisor mode masks IRQ.
        p_fetch(6'h21, 1'b1, 1'b1);
        p_exec(6'h21);
        // IRQ raised only after the entry cycle is not sampled.
        push(1'b0, 1'b0, 1'b0, 1'b0, 6'h20, v(1, 0, 0, 0, 0, 0, 0, 3'd0, cause));
        p_fetch(6'h20, 1'b1, 1'b0);
        p_exec(6'h20);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL irq step %0d got=%h exp=%h", n, got, s.exp); end
            else $display("irq step %0d out=%h", n, got);
            n++;
        end
        sif.IRQ = 1'b0;
        sif.pc_sup = 1'b1;
    endtask

    task automatic test_timeout();
        step_t s; logic [11:0] got; int n = 0;
        for (int k = 0; k < TO; k++) push(1'b0, 1'b0, 1'b0, 1'b1, 6'h20, v(1, 0, 0, 0, 0, 0, 0, 3'd0, cause));
        p_trap(3'd3, 2'd3);
        p_fetch(6'h18, 1'b0, 1'b1);
        p_idle(6'h18);
        for (int k = 0; k < TO; k++) push(1'b0, 1'b0, 1'b0, 1'b1, 6'h18, v(1, 0, 1, 0, 0, 0, 0, 3'd0, cause));
        p_trap(3'd3, 2'd3);
        p_fetch(6'h20, 1'b0, 1'b1);
        p_exec(6'h20);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL timeout step %0d got=%h exp=%h", n, got, s.exp); end
            else $display("timeout step %0d out=%h", n, got);
            n++;
        end
    endtask

    task automatic test_reset_mid();
        step_t s; logic [11:0] got; int n = 0;
        for (int k = 0; k < 2; k++) push(1'b0, 1'b0, 1'b0, 1'b1, 6'h20, v(1, 0, 0, 0, 0, 0, 0, 3'd0, cause));
        push(1'b1, 1'b1, 1'b0, 1'b1, 6'h20, 12'h000);
        push(1'b1, 1'b0, 1'b0, 1'b1, 6'h20, 12'h000);
        cause = 2'd0;
        p_fetch(6'h19, 1'b0, 1'b1);
        p_idle(6'h19);
        push(1'b0, 1'b0, 1'b0, 1'b1, 6'h19, v(1, 1, 1, 0, 0, 0, 0, 3'd0, cause));
        push(1'b1, 1'b1, 1'b0, 1'b1, 6'h19, 12'h000);
        push(1'b0, 1'b0, 1'b0, 1'b1, 6'h20, v(1, 0, 0, 0, 0, 0, 0, 3'd0, cause));
        p_fetch(6'h20, 1'b0, 1'b1);
        p_exec(6'h20);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            RESET = s.rst; sif.mem_ready = s.rdy; sif.IRQ = s.irq; sif.pc_sup = s.psup; sif.op_code = s.op;
            #1; got = obs(); checks++;
            if (got !== s.exp) begin errors++; $display("FAIL reset_mid step %0d got=%h exp=%h", n, got, s.exp); end
            else $display("reset_mid step %0d out=%h", n, got);
            n++;
        end
    endtask

    initial begin
        sif.op_code   = 6'h20;
        sif.pc_sup    = 1'b1;
        sif.IRQ       = 1'b0;
        sif.mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_ld();
        test_st();
        test_illop();
        test_irq();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
